harris_pipe_sequencer: RTL and testbench

- Controller for the two-stage Harris structure-tensor datapath.
- Generates the datapath's single `advance` enable from a valid/ready handshake on each side.
- Tracks a valid bit and pixel coordinates alongside each datapath stage.
- Sequences whole frames: idle, accept W*H windows, drain, signal done.

---
 rtl/harris_pipe_sequencer_pkg.sv | 38 +++
 rtl/harris_pipe_sequencer_tag_pipe.sv | 48 ++++
 rtl/harris_pipe_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_harris_pipe_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harris_pipe_sequencer_pkg.sv
// Shared types and constants for the Harris structure-tensor pipeline sequencer.
// Holds the controller state encoding, the coordinate type, the per-stage tag
// that travels alongside the datapath, and the performance counter width.
package harris_pkg;

    // Width of x/y coordinates; must hold IMG_WIDTH-1 and IMG_HEIGHT-1.
    localparam int COORD_BITS    = 10;
    // Width of the optional performance counters.
    localparam int PERF_CNT_BITS = 32;

    // Frame-level controller state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } seq_state_t;

    typedef logic [COORD_BITS-1:0] coord_t;

    // Side-band information carried next to each registered datapath stage.
    typedef struct packed {
        logic   valid;
        coord_t x;
        coord_t y;
        logic   border;
        logic   last;
    } stage_tag_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PERF_CNT_BITS-1:0] sat_inc(
        input logic [PERF_CNT_BITS-1:0] value
    );
        logic [PERF_CNT_BITS-1:0] one;
        one = {{(PERF_CNT_BITS-1){1'b0}}, 1'b1};
        return (&value) ? value : value + one;
    endfunction

endpackage

// File: rtl/harris_pipe_sequencer_tag_pipe.sv
// harris_tag_pipe: PIPE_DEPTH-deep shift register of stage_tag_t.
// Every stage moves forward together when advance_i is high and holds
// otherwise, mirroring the pipeline registers of the Harris datapath so the
// valid bit and coordinates of a stage always describe the data in that stage.
module harris_tag_pipe
    import harris_pkg::*;
#(
    parameter int PIPE_DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance_i,
    input  stage_tag_t tag_i,
    output stage_tag_t tag_o
);

    stage_tag_t stage_q [PIPE_DEPTH];
    stage_tag_t stage_d [PIPE_DEPTH];

    // Next stage contents: shift on advance, hold everything otherwise.
    always_comb begin
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (advance_i) begin
            stage_d[0] = tag_i;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Stage registers; reset clears valid bits and payload alike.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tag_o = stage_q[PIPE_DEPTH-1];

endmodule

// File: rtl/harris_pipe_sequencer.sv
// harris_pipe_sequencer: frame controller for the two-stage Harris
// structure-tensor datapath. It produces the single datapath enable
// (advance), tags each accepted window with its coordinates, border and
// end-of-frame flags, and walks IDLE -> RUN -> FLUSH -> IDLE per frame.
//
// Handshakes: a window transfers on a cycle where win_valid && win_ready,
// a matrix transfers on a cycle where mat_valid && mat_ready. Neither valid
// may depend on the matching ready; win_ready and advance depend on
// mat_ready combinationally, mat_valid is a registered bit.
//
// Optional build macro HARRIS_PIPE_SEQ_PERF_EN adds saturating perf_stall,
// perf_bubble and perf_cycles counter outputs.
module harris_pipe_sequencer
    import harris_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COORD_BITS = harris_pkg::COORD_BITS,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  win_valid,
    output logic                  win_ready,
    output logic                  advance,
    output logic                  mat_valid,
    input  logic                  mat_ready,
    output logic [COORD_BITS-1:0] mat_x,
    output logic [COORD_BITS-1:0] mat_y,
    output logic                  mat_border,
    output logic                  mat_last,
    output logic                  busy,
    output seq_state_t            dbg_state,
    output logic                  frame_done
`ifdef HARRIS_PIPE_SEQ_PERF_EN
    ,
    output logic [PERF_CNT_BITS-1:0] perf_stall,
    output logic [PERF_CNT_BITS-1:0] perf_bubble,
    output logic [PERF_CNT_BITS-1:0] perf_cycles
`endif
);

    localparam coord_t X_LAST = coord_t'(IMG_WIDTH - 1);
    localparam coord_t Y_LAST = coord_t'(IMG_HEIGHT - 1);
    localparam coord_t ONE    = coord_t'(1);

    seq_state_t state_q, state_d;
    coord_t     in_x_q, in_x_d;
    coord_t     in_y_q, in_y_d;
    logic       frame_done_q, frame_done_d;

    stage_tag_t in_tag;
    stage_tag_t out_tag;

    logic accept;
    logic start_frame;
    logic last_beat;
    logic in_border;
    logic in_last;

    // Datapath enable: move unless the output stage holds data nobody takes.
    always_comb begin
        advance = !out_tag.valid || mat_ready;
    end

    // Frame start is only honoured from IDLE; tags describe the window at the counters.
    always_comb begin
        start_frame = (state_q == IDLE) && frame_start;
        accept      = win_valid && win_ready;
        last_beat   = out_tag.valid && mat_ready && out_tag.last;
        in_border   = (in_x_q == '0) || (in_x_q == X_LAST) ||
                      (in_y_q == '0) || (in_y_q == Y_LAST);
        in_last     = (in_x_q == X_LAST) && (in_y_q == Y_LAST);
    end

    // Tag presented to stage 0; valid only when a window is actually accepted.
    always_comb begin
        in_tag        = '0;
        in_tag.valid  = accept;
        in_tag.x      = in_x_q;
        in_tag.y      = in_y_q;
        in_tag.border = in_border;
        in_tag.last   = in_last;
    end

    harris_tag_pipe #(
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .advance_i (advance),
        .tag_i     (in_tag),
        .tag_o     (out_tag)
    );

    // Output fields come straight from the last stage registers.
    always_comb begin
        mat_valid  = out_tag.valid;
        mat_x      = out_tag.x;
        mat_y      = out_tag.y;
        mat_border = out_tag.border;
        mat_last   = out_tag.last;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start, stop accepting after the last window, finish on the last beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start)          state_d = RUN;
            RUN:     if (accept && in_last)    state_d = FLUSH;
            FLUSH:   if (last_beat)            state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy         = (state_q != IDLE);
        win_ready    = (state_q == RUN) && advance;
        dbg_state    = state_q;
        frame_done_d = (state_q == FLUSH) && last_beat;
    end

    // Raster counters: cleared when a frame starts, stepped once per accepted window.
    always_comb begin
        in_x_d = in_x_q;
        in_y_d = in_y_q;
        if (start_frame) begin
            in_x_d = '0;
            in_y_d = '0;
        end else if (accept) begin
            if (in_x_q == X_LAST) begin
                in_x_d = '0;
                in_y_d = (in_y_q == Y_LAST) ? '0 : in_y_q + ONE;
            end else begin
                in_x_d = in_x_q + ONE;
            end
        end
    end

    // Counter and done-pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_x_q       <= '0;
            in_y_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            in_x_q       <= in_x_d;
            in_y_q       <= in_y_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done = frame_done_q;

`ifdef HARRIS_PIPE_SEQ_PERF_EN
    logic [PERF_CNT_BITS-1:0] perf_stall_q,  perf_stall_d;
    logic [PERF_CNT_BITS-1:0] perf_bubble_q, perf_bubble_d;
    logic [PERF_CNT_BITS-1:0] perf_cycles_q, perf_cycles_d;

    // Saturating event counters, restarted at every honoured frame start.
    always_comb begin
        perf_stall_d  = perf_stall_q;
        perf_bubble_d = perf_bubble_q;
        perf_cycles_d = perf_cycles_q;
        if (start_frame) begin
            perf_stall_d  = '0;
            perf_bubble_d = '0;
            perf_cycles_d = '0;
        end else begin
            if (out_tag.valid && !mat_ready) perf_stall_d  = sat_inc(perf_stall_q);
            if ((state_q == RUN) && !win_valid) perf_bubble_d = sat_inc(perf_bubble_q);
            if (busy) perf_cycles_d = sat_inc(perf_cycles_q);
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q  <= '0;
            perf_bubble_q <= '0;
            perf_cycles_q <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_bubble_q <= perf_bubble_d;
            perf_cycles_q <= perf_cycles_d;
        end
    end

    assign perf_stall  = perf_stall_q;
    assign perf_bubble = perf_bubble_q;
    assign perf_cycles = perf_cycles_q;
`endif

endmodule

// File: tb/tb_harris_pipe_sequencer.sv
// Bench for harris_pipe_sequencer with a 4x3 frame. A frame model lists the
// expected matrices in raster order; a monitor pops it on every output beat.
// Per-scenario tasks drive frames and inspect a recorded cycle trace.
module tb_harris_pipe_sequencer;
    import harris_pkg::*;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int CB    = 10;
    localparam int PD    = 2;
    localparam int TAG_W = 2 * CB + 2;
    localparam int MAXC  = 256;

    logic clk = 1'b0;
    logic reset, frame_start, win_valid, mat_ready;
    logic win_ready, advance, mat_valid, mat_border, mat_last, busy, frame_done;
    logic [CB-1:0] mat_x, mat_y;
    seq_state_t dbg_state;
`ifdef HARRIS_PIPE_SEQ_PERF_EN
    logic [31:0] perf_stall, perf_bubble, perf_cycles;
    logic [31:0] s_stall, s_bubble, s_cycles;
`endif

    int checks   = 0;
    int failures = 0;
    logic [TAG_W-1:0] exp_q[$];

    // Cycle trace of the most recent run_frame call.
    logic t_wv [MAXC], t_wr [MAXC], t_adv [MAXC], t_mv [MAXC];
    logic t_mr [MAXC], t_last [MAXC], t_busy [MAXC], t_fd [MAXC];
    logic [CB-1:0] t_x [MAXC], t_y [MAXC];
    int t_n, t_accepts, t_beats;
    bit t_timeout;

    // Clock and reset block.
    always #5 clk = ~clk;

    harris_pipe_sequencer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .COORD_BITS (CB),
        .PIPE_DEPTH (PD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .advance     (advance),
        .mat_valid   (mat_valid),
        .mat_ready   (mat_ready),
        .mat_x       (mat_x),
        .mat_y       (mat_y),
        .mat_border  (mat_border),
        .mat_last    (mat_last),
        .busy        (busy),
        .dbg_state   (dbg_state),
        .frame_done  (frame_done)
`ifdef HARRIS_PIPE_SEQ_PERF_EN
        ,
        .perf_stall  (perf_stall),
        .perf_bubble (perf_bubble),
        .perf_cycles (perf_cycles)
`endif
    );

    // Scoreboard: every output beat must be the next matrix of the frame model.
    always @(negedge clk) begin
        #2;
        if (!reset && mat_valid && mat_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_beat got x=%0d y=%0d exp=none", mat_x, mat_y);
            end else begin
                logic [TAG_W-1:0] e;
                e = exp_q.pop_front();
                if ({mat_x, mat_y, mat_border, mat_last} !== e) begin
                    failures++;
                    $display("FAIL sb_beat got x=%0d y=%0d b=%0b l=%0b exp x=%0d y=%0d b=%0b l=%0b",
                             mat_x, mat_y, mat_border, mat_last,
                             e[TAG_W-1 -: CB], e[CB+1 -: CB], e[1], e[0]);
                end
            end
        end
    end

    // Reference frame: raster order, edge pixels flagged, final pixel flagged last.
    task automatic load_model();
        exp_q.delete();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                logic b, l;
                b = (x == 0) || (x == W - 1) || (y == 0) || (y == H - 1);
                l = (x == W - 1) && (y == H - 1);
                exp_q.push_back({CB'(x), CB'(y), b, l});
            end
        end
    endtask

    // Driver: apply inputs on the falling edge, leave outputs settled for sampling.
    task automatic drive(input logic fs, input logic wv, input logic mr);
        @(negedge clk);
        frame_start = fs;
        win_valid   = wv;
        mat_ready   = mr;
        #2;
    endtask

    // Drive one frame with a given stimulus mode and record the trace.
    // 0 continuous, 1 five-cycle stall, 2 alternating bubbles, 3 frame_start
    // at window 5, 4 random, 5 stall plus three bubbles, 6 frame_start on the
    // final beat.
    task automatic run_frame(input int mode);
        int  stall_left = 0;
        bit  stall_done = 0;
        bit  fs_done    = 0;
        bit  prev_bub   = 0;
        int  bub_n      = 0;
        load_model();
        t_n = 0; t_timeout = 1; t_accepts = 0; t_beats = 0;
        for (int i = 0; i < MAXC; i++) begin
            bit fs, wv, mr;
            fs = (i == 0); wv = 1'b1; mr = 1'b1;
            if ((mode == 1 || mode == 5) && !stall_done && t_beats >= 3) begin
                stall_left = 5; stall_done = 1;
            end
            if (stall_left > 0) begin mr = 1'b0; stall_left--; end
            if (mode == 2) wv = (i % 2 == 1);
            if (mode == 3 && !fs_done && t_accepts == 5) begin fs = 1'b1; fs_done = 1; end
            if (mode == 4) begin
                wv = ($urandom_range(0, 3) != 0);
                mr = ($urandom_range(0, 3) != 0);
            end
            if (mode == 5 && stall_done && stall_left == 0 && t_accepts >= 6 && bub_n < 3 && !prev_bub) begin
                wv = 1'b0; bub_n++; prev_bub = 1;
            end else begin
                prev_bub = 0;
            end
            drive(fs, wv, mr);
            t_wv[i] = win_valid;  t_wr[i] = win_ready; t_adv[i] = advance;
            t_mv[i] = mat_valid;  t_mr[i] = mat_ready; t_last[i] = mat_last;
            t_busy[i] = busy;     t_fd[i] = frame_done;
            t_x[i] = mat_x;       t_y[i] = mat_y;
`ifdef HARRIS_PIPE_SEQ_PERF_EN
            s_stall = perf_stall; s_bubble = perf_bubble; s_cycles = perf_cycles;
`endif
            if (win_valid && win_ready) t_accepts++;
            if (mat_valid && mat_ready) t_beats++;
            if (mode == 6 && mat_valid && mat_ready && mat_last) frame_start = 1'b1;
            t_n = i + 1;
            if (frame_done) begin t_timeout = 0; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        checks++; if (mat_valid !== 1'b0)  begin failures++; $display("FAIL reset_mat_valid got=%0b exp=0", mat_valid); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%0b exp=0", frame_done); end
        checks++; if ({mat_x, mat_y, mat_border, mat_last} !== '0) begin
            failures++; $display("FAIL reset_mat_fields got x=%0d y=%0d b=%0b l=%0b exp all 0", mat_x, mat_y, mat_border, mat_last);
        end
        checks++; if (win_ready !== 1'b0)  begin failures++; $display("FAIL reset_win_ready got=%0b exp=0", win_ready); end
        checks++; if (advance !== 1'b1)    begin failures++; $display("FAIL reset_advance got=%0b exp=1", advance); end
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b1);
        checks++; if (win_ready !== 1'b0)  begin failures++; $display("FAIL idle_win_ready got=%0b exp=0", win_ready); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL idle_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_basic();
        int fa = -1, fv = -1, l_idx = -1, nv = 0;
        run_frame(0);
        checks++; if (t_timeout) begin failures++; $display("FAIL basic_timeout got=no frame_done exp=frame_done"); end
        for (int i = 0; i < t_n; i++) begin
            if (fa < 0 && t_wv[i] && t_wr[i]) fa = i;
            if (fv < 0 && t_mv[i]) fv = i;
            if (t_mv[i]) nv++;
            if (t_mv[i] && t_mr[i] && t_last[i]) l_idx = i;
        end
        checks++; if (fv - fa != PD) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", fv - fa, PD); end
        checks++; if (t_accepts != W * H) begin failures++; $display("FAIL basic_accepts got=%0d exp=%0d", t_accepts, W * H); end
        checks++; if (t_beats != W * H) begin failures++; $display("FAIL basic_beats got=%0d exp=%0d", t_beats, W * H); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL basic_leftover got=%0d exp=0", exp_q.size()); end
        checks++; if (nv != W * H || l_idx - fv != W * H - 1) begin
            failures++; $display("FAIL basic_contiguous got valid=%0d span=%0d exp valid=%0d span=%0d", nv, l_idx - fv, W * H, W * H - 1);
        end
        checks++; if (l_idx != t_n - 2) begin failures++; $display("FAIL basic_done_edge got last=%0d done=%0d exp done=last+1", l_idx, t_n - 1); end
        checks++; if (l_idx < 0 || t_busy[l_idx] !== 1'b1 || t_busy[t_n-1] !== 1'b0) begin
            failures++; $display("FAIL basic_busy_fall got=%0b,%0b exp=1,0", (l_idx >= 0) ? t_busy[l_idx] : 1'bx, t_busy[t_n-1]);
        end
        drive(1'b0, 1'b0, 1'b1);
        checks++; if (frame_done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_done_pulse got done=%0b busy=%0b exp 0,0", frame_done, busy);
        end
    endtask

    task automatic test_backpressure();
        int n_stall = 0;
        run_frame(1);
        checks++; if (t_timeout) begin failures++; $display("FAIL bp_timeout got=no frame_done exp=frame_done"); end
        checks++; if (t_beats != W * H || t_accepts != W * H || exp_q.size() != 0) begin
            failures++; $display("FAIL bp_counts got beats=%0d acc=%0d left=%0d exp %0d,%0d,0", t_beats, t_accepts, exp_q.size(), W * H, W * H);
        end
        for (int i = 0; i + 1 < t_n; i++) begin
            if (!t_mr[i] && t_mv[i]) begin
                n_stall++;
                checks++; if (t_adv[i] !== 1'b0 || t_wr[i] !== 1'b0) begin
                    failures++; $display("FAIL bp_freeze cyc=%0d got adv=%0b wr=%0b exp 0,0", i, t_adv[i], t_wr[i]);
                end
                checks++; if (t_mv[i+1] !== 1'b1 || t_x[i+1] !== t_x[i] || t_y[i+1] !== t_y[i]) begin
                    failures++; $display("FAIL bp_hold cyc=%0d got v=%0b x=%0d y=%0d exp v=1 x=%0d y=%0d", i, t_mv[i+1], t_x[i+1], t_y[i+1], t_x[i], t_y[i]);
                end
            end
        end
        checks++; if (n_stall != 5) begin failures++; $display("FAIL bp_stall_cycles got=%0d exp=5", n_stall); end
    endtask

    task automatic test_bubbles();
        int acc = 0, gaps = 0, fv = -1, lv = -1;
        run_frame(2);
        checks++; if (t_timeout || t_beats != W * H || exp_q.size() != 0) begin
            failures++; $display("FAIL bub_counts got timeout=%0b beats=%0d exp 0,%0d", t_timeout, t_beats, W * H);
        end
        for (int i = 0; i < t_n; i++) begin
            if (t_busy[i] && acc < W * H && i + PD < t_n) begin
                checks++; if (t_mv[i+PD] !== (t_wv[i] && t_wr[i])) begin
                    failures++; $display("FAIL bub_slot cyc=%0d got mv=%0b exp=%0b", i + PD, t_mv[i+PD], t_wv[i] && t_wr[i]);
                end
            end
            if (t_wv[i] && t_wr[i]) acc++;
            if (t_mv[i]) begin if (fv < 0) fv = i; lv = i; end
        end
        for (int i = fv; i >= 0 && i <= lv; i++) if (!t_mv[i]) gaps++;
        checks++; if (gaps != W * H - 1) begin failures++; $display("FAIL bub_gaps got=%0d exp=%0d", gaps, W * H - 1); end
    endtask

    task automatic test_frame_start_in_run();
        run_frame(3);
        checks++; if (t_timeout || t_beats != W * H || t_accepts != W * H || exp_q.size() != 0) begin
            failures++; $display("FAIL fs_run_counts got timeout=%0b beats=%0d acc=%0d exp 0,%0d,%0d", t_timeout, t_beats, t_accepts, W * H, W * H);
        end
        drive(1'b0, 1'b1, 1'b1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fs_run_idle got busy=%0b exp=0", busy); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            run_frame(4);
            checks++; if (t_timeout || t_beats != W * H || t_accepts != W * H || exp_q.size() != 0) begin
                failures++; $display("FAIL rnd_counts frame=%0d got timeout=%0b beats=%0d acc=%0d", f, t_timeout, t_beats, t_accepts);
            end
            for (int i = 0; i < t_n; i++) begin
                checks++; if (t_adv[i] !== (!t_mv[i] || t_mr[i]) || (t_wr[i] && !(t_adv[i] && t_busy[i]))) begin
                    failures++; $display("FAIL rnd_rule cyc=%0d got adv=%0b wr=%0b exp adv=%0b", i, t_adv[i], t_wr[i], !t_mv[i] || t_mr[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        run_frame(6);
        checks++; if (t_timeout || t_beats != W * H) begin
            failures++; $display("FAIL b2b_counts got timeout=%0b beats=%0d exp 0,%0d", t_timeout, t_beats, W * H);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            checks++; if (busy !== 1'b0 || win_ready !== 1'b0) begin
                failures++; $display("FAIL b2b_ignored cyc=%0d got busy=%0b wr=%0b exp 0,0", i, busy, win_ready);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int acc = 0;
        exp_q.delete();
        drive(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            if (win_valid && win_ready) acc++;
            if (acc == 2 && mat_valid) break;
        end
        checks++; if (acc != 2 || mat_valid !== 1'b1) begin
            failures++; $display("FAIL rst_mid_setup got acc=%0d mv=%0b exp 2,1", acc, mat_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        frame_start = 1'b0; win_valid = 1'b1; mat_ready = 1'b1;
        #2;
        checks++; if (mat_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++; $display("FAIL rst_mid_after got mv=%0b busy=%0b done=%0b exp 0,0,0", mat_valid, busy, frame_done);
        end
        drive(1'b0, 1'b0, 1'b1);
        checks++; if (frame_done !== 1'b0 || mat_valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid_no_done got done=%0b mv=%0b exp 0,0", frame_done, mat_valid);
        end
        run_frame(0);
        checks++; if (t_timeout || t_beats != W * H || exp_q.size() != 0) begin
            failures++; $display("FAIL rst_mid_restart got timeout=%0b beats=%0d exp 0,%0d", t_timeout, t_beats, W * H);
        end
    endtask

`ifdef HARRIS_PIPE_SEQ_PERF_EN
    task automatic test_perf();
        int nbusy = 0;
        run_frame(5);
        for (int i = 0; i + 1 < t_n; i++) if (t_busy[i]) nbusy++;
        checks++; if (t_timeout) begin failures++; $display("FAIL perf_timeout got=no frame_done exp=frame_done"); end
        checks++; if (s_stall !== 32'd5) begin failures++; $display("FAIL perf_stall got=%0d exp=5", s_stall); end
        checks++; if (s_bubble !== 32'd3) begin failures++; $display("FAIL perf_bubble got=%0d exp=3", s_bubble); end
        checks++; if (s_cycles !== 32'(nbusy)) begin failures++; $display("FAIL perf_cycles got=%0d exp=%0d", s_cycles, nbusy); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; frame_start = 1'b0; win_valid = 1'b0; mat_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_bubbles();
        test_frame_start_in_run();
        test_random();
        test_back_to_back();
        test_reset_midframe();
`ifdef HARRIS_PIPE_SEQ_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
